// File: rtl/vedic_mac16.sv
// Pipelined unsigned multiply-accumulate stage with a vedic 16x16 multiplier.
// Packets are delimited by a last flag; one accumulated result is emitted per packet.

module vedic_2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] c
);
  logic pp_lo_s;
  logic pp_x0_s;
  logic pp_x1_s;
  logic pp_hi_s;
  logic carry_s;

  assign pp_lo_s = a[0] & b[0];
  assign pp_x0_s = a[1] & b[0];
  assign pp_x1_s = a[0] & b[1];
  assign pp_hi_s = a[1] & b[1];
  assign carry_s = pp_x0_s & pp_x1_s;

  assign c[0] = pp_lo_s;
  assign c[1] = pp_x0_s ^ pp_x1_s;
  assign c[2] = pp_hi_s ^ carry_s;
  assign c[3] = pp_hi_s & carry_s;
endmodule

module vedic_4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] c
);
  logic [3:0] q_ll_s;
  logic [3:0] q_hl_s;
  logic [3:0] q_lh_s;
  logic [3:0] q_hh_s;
  logic [4:0] mid_s;
  logic [7:0] mid_ext_s;

  vedic_2x2 u_ll (.a(a[1:0]), .b(b[1:0]), .c(q_ll_s));
  vedic_2x2 u_hl (.a(a[3:2]), .b(b[1:0]), .c(q_hl_s));
  vedic_2x2 u_lh (.a(a[1:0]), .b(b[3:2]), .c(q_lh_s));
  vedic_2x2 u_hh (.a(a[3:2]), .b(b[3:2]), .c(q_hh_s));

  // Cross terms sit at half weight between the low and high products.
  assign mid_s     = {1'b0, q_hl_s} + {1'b0, q_lh_s};
  assign mid_ext_s = {1'b0, mid_s, 2'b00};
  assign c         = {q_hh_s, q_ll_s} + mid_ext_s;
endmodule

module vedic_8x8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] c
);
  logic [7:0]  q_ll_s;
  logic [7:0]  q_hl_s;
  logic [7:0]  q_lh_s;
  logic [7:0]  q_hh_s;
  logic [8:0]  mid_s;
  logic [15:0] mid_ext_s;

  vedic_4x4 u_ll (.a(a[3:0]), .b(b[3:0]), .c(q_ll_s));
  vedic_4x4 u_hl (.a(a[7:4]), .b(b[3:0]), .c(q_hl_s));
  vedic_4x4 u_lh (.a(a[3:0]), .b(b[7:4]), .c(q_lh_s));
  vedic_4x4 u_hh (.a(a[7:4]), .b(b[7:4]), .c(q_hh_s));

  assign mid_s     = {1'b0, q_hl_s} + {1'b0, q_lh_s};
  assign mid_ext_s = {3'b000, mid_s, 4'h0};
  assign c         = {q_hh_s, q_ll_s} + mid_ext_s;
endmodule

module vedic_16x16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] c
);
  logic [15:0] q_ll_s;
  logic [15:0] q_hl_s;
  logic [15:0] q_lh_s;
  logic [15:0] q_hh_s;
  logic [16:0] mid_s;
  logic [31:0] mid_ext_s;

  vedic_8x8 u_ll (.a(a[7:0]),  .b(b[7:0]),  .c(q_ll_s));
  vedic_8x8 u_hl (.a(a[15:8]), .b(b[7:0]),  .c(q_hl_s));
  vedic_8x8 u_lh (.a(a[7:0]),  .b(b[15:8]), .c(q_lh_s));
  vedic_8x8 u_hh (.a(a[15:8]), .b(b[15:8]), .c(q_hh_s));

  assign mid_s     = {1'b0, q_hl_s} + {1'b0, q_lh_s};
  assign mid_ext_s = {7'd0, mid_s, 8'd0};
  assign c         = {q_hh_s, q_ll_s} + mid_ext_s;
endmodule

module vedic_mac16 #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);
  logic             en_s;
  logic             accept_s;
  logic             s1_valid_r;
  logic [15:0]      s1_a_r;
  logic [15:0]      s1_b_r;
  logic             s1_last_r;
  logic [31:0]      prod_s;
  logic             s2_valid_r;
  logic [31:0]      s2_p_r;
  logic             s2_last_r;
  logic [ACC_W-1:0] acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic             ovf_r;
  logic [ACC_W:0]   sum_s;
  logic             ovf_n_s;
  logic [CNT_W-1:0] cnt_n_s;

  // A pending result that downstream refuses freezes every stage at once.
  assign en_s     = ~(out_valid & ~out_ready);
  assign in_ready = en_s & ~rst;
  assign accept_s = in_valid & in_ready;

  // S1 operand capture; bubbles load an invalid slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= 16'd0;
      s1_b_r     <= 16'd0;
      s1_last_r  <= 1'b0;
    end else if (en_s) begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_a_r    <= in_a;
        s1_b_r    <= in_b;
        s1_last_r <= in_last;
      end
    end
  end

  vedic_16x16 u_mul (.a(s1_a_r), .b(s1_b_r), .c(prod_s));

  // S2 product register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      s2_p_r     <= 32'd0;
      s2_last_r  <= 1'b0;
    end else if (en_s) begin
      s2_valid_r <= s1_valid_r;
      s2_p_r     <= prod_s;
      s2_last_r  <= s1_last_r;
    end
  end

  // S3 next-state arithmetic: one extra bit catches the carry out of the accumulator.
  always_comb begin
    sum_s   = {1'b0, acc_r} + {{(ACC_W-31){1'b0}}, s2_p_r};
    ovf_n_s = ovf_r | sum_s[ACC_W];
    if (cnt_r == {CNT_W{1'b1}}) begin
      cnt_n_s = cnt_r;
    end else begin
      cnt_n_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // S3 accumulate / emit; a last beat hands off and clears in the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r     <= {ACC_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      ovf_r     <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= {ACC_W{1'b0}};
      out_count <= {CNT_W{1'b0}};
      out_ovf   <= 1'b0;
    end else if (en_s) begin
      if (s2_valid_r) begin
        if (s2_last_r) begin
          out_acc   <= sum_s[ACC_W-1:0];
          out_ovf   <= ovf_n_s;
          out_count <= cnt_n_s;
          out_valid <= 1'b1;
          acc_r     <= {ACC_W{1'b0}};
          cnt_r     <= {CNT_W{1'b0}};
          ovf_r     <= 1'b0;
        end else begin
          acc_r     <= sum_s[ACC_W-1:0];
          cnt_r     <= cnt_n_s;
          ovf_r     <= ovf_n_s;
          out_valid <= 1'b0;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/vedic_mac16.md
Name: vedic_mac16

Overview:
- Pipelined multiply-accumulate stage built around vedic_16x16 (combinational, ports a[15:0], b[15:0], c[31:0]).
- Accepts a stream of 16-bit unsigned operand pairs grouped into packets by a last flag.
- Emits one accumulated sum of products per packet, with a beat count and an overflow flag.
- Sits directly downstream of operand sourcing and consumes every product vedic_16x16 produces.

Parameters:
- ACC_W, 40, accumulator/result width in bits; legal range 32..64.
- CNT_W, 8, width of the per-packet beat counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  stage can accept a beat.
- in_a  input  16  unsigned multiplicand.
- in_b  input  16  unsigned multiplier.
- in_last  input  1  beat closes the current packet.
- out_valid  output  1  packet result valid.
- out_ready  input  1  downstream accepts result.
- out_acc  output  ACC_W  sum of all products in the packet, modulo 2^ACC_W.
- out_count  output  CNT_W  beats in the packet; saturates at 2^CNT_W-1.
- out_ovf  output  1  accumulation carried out of ACC_W at least once in the packet.

Behaviour:
- Reset (async assert, sync release) clears:
  - all pipeline valids, the accumulator, the counter and the sticky overflow;
  - out_valid=0, out_acc=0, out_count=0, out_ovf=0.
- in_ready is 0 while rst is high.
- Global enable: en = !(out_valid && !out_ready). in_ready = en. All stages advance only when en=1; when en=0 every register holds.
- Beat handshake: a beat is accepted at a rising edge with in_valid && in_ready.
- S1: registers in_a, in_b, in_last and valid on the accepting edge. Bubbles, i.e. en=1 with no handshake, load valid=0.
- S2: a vedic_16x16 instance drives p = s1_a*s1_b. S2 registers p, s1_last and s1_valid.
- S3, on en with s2_valid:
  - sum = acc + {0,p}, computed at ACC_W+1 bits.
  - ovf_n = ovf | sum[ACC_W].
  - cnt_n = saturating cnt+1.
- If s2_last = 0:
  - acc <= sum[ACC_W-1:0], ovf <= ovf_n, cnt <= cnt_n.
  - out_valid falls to 0 if it was 1; en=1 implies out_ready.
- If s2_last = 1:
  - out_acc <= sum[ACC_W-1:0], out_ovf <= ovf_n, out_count <= cnt_n, out_valid <= 1.
  - acc, ovf and cnt clear to 0 on the same edge, so the next packet starts clean with no dead cycle.
- If en with no s2_valid: out_valid <= 0 (consumed or idle); output data holds.
- Latency: a last beat accepted at edge k gives out_valid=1 after edge k+2.
  - Throughput is one beat per cycle.
  - One-beat packets may arrive back-to-back; out_valid then stays high across consecutive results while out_ready=1.
- Backpressure: out_valid=1 with out_ready=0 freezes the whole pipe.
  - in_ready=0 during the freeze.
  - No beat is lost or duplicated.
  - out_* remain stable until accepted.
- Packet state machine, implicit in cnt and out_valid:
  - IDLE: cnt=0, no result pending.
  - ACCUM: cnt>0.
  - HOLD: result pending with out_ready=0.
  - Transitions: ACCUM→HOLD on last; HOLD→IDLE/ACCUM on accept.
- Wrap-around: out_acc is modulo 2^ACC_W. out_ovf is sticky for the packet and clears with the next packet.
- Counter saturation: out_count sticks at 2^CNT_W-1 and does not wrap.
- Reset mid-packet: the partial packet is discarded entirely. Operands in S1/S2 are dropped and no result is emitted for them.
- in_valid without in_last: the packet stays open indefinitely. No timeout.

Test Plan:
- Single-beat packet:
  - Stimulus: a=12, b=12, last=1.
  - Response: out_valid 2 edges after acceptance; out_acc=144, out_count=1, out_ovf=0.
- Five-beat packet, streamed one per cycle with out_ready=1:
  - Stimulus: (12,12), (15,13), (24,2), (200,21), (36,48 last).
  - Response: out_acc=6315, out_count=5, out_ovf=0; exactly one out_valid pulse.
- Overflow, with ACC_W=32:
  - Stimulus: two beats (65535,65535), the second with last.
  - Response: out_acc=4294705154, out_ovf=1.
  - Follow-up: the next packet (0,0 last) gives out_acc=0, out_ovf=0.
- Backpressure:
  - Stimulus: out_ready=0; send (2,3 last), then (4,5 last), in_valid held high.
  - Response while stalled: out_valid=1 with out_acc=6 stable; in_ready=0.
  - Response after releasing out_ready: results 6 then 20 on consecutive cycles; no third result.
- Reset mid-packet:
  - Stimulus: send (100,100), (7,7) without last; assert rst for 1 cycle; then send (3,3 last).
  - Response: outputs are 0 during reset; the single result is out_acc=9, out_count=1.
- Counter saturation, with CNT_W=2:
  - Stimulus: 5 beats of (1,1), the last with last=1.
  - Response: out_count=3, out_acc=5.
